// File: rtl/ibexsis_pkg.sv
// Shared types and constants for the Ibex data-port to AXI4-lite bridge.
package ibexsis_pkg;

    // Bridge sequencing states; exported on the debug state port.
    typedef enum logic [2:0] {
        IDLE,
        WADDR_DATA,
        WRESP,
        RADDR,
        RDATA,
        RESP
    } bridge_state_e;

    // AXI response codes; bit 1 set means the access failed.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Peripheral map: IO module first, Timer1 last.
    localparam logic [31:0] ADDR_BASE_IOMODULE = 32'h0000_4000;
    localparam logic [31:0] ADDR_BASE_TIMER1   = 32'h0000_40D0;
    localparam logic [31:0] SIZE_TIMER1        = 32'h0000_0008;

    // Bridge window: [PERIPH_LO, PERIPH_HI).
    localparam logic [31:0] PERIPH_LO = ADDR_BASE_IOMODULE;
    localparam logic [31:0] PERIPH_HI = ADDR_BASE_TIMER1 + SIZE_TIMER1;

endpackage

// File: rtl/addr_window_check.sv
// Combinational check that a byte address falls inside [ADDR_LO, ADDR_HI).
module addr_window_check #(
    parameter int            AW      = 32,
    parameter logic [AW-1:0] ADDR_LO = '0,
    parameter logic [AW-1:0] ADDR_HI = '0
) (
    input  logic [AW-1:0] addr,
    output logic          in_win
);

    assign in_win = (addr >= ADDR_LO) && (addr < ADDR_HI);

endmodule

// File: rtl/ibex_axi4lite_bridge.sv
// Ibex data-memory port to single-outstanding AXI4-lite master for the
// peripheral window. Out-of-window accesses complete locally with err=1.
//
// Handshake rule on every AXI channel: a transfer happens on the rising edge
// where valid and ready are both high; a raised valid and its payload hold
// until that edge and the valid drops on the following cycle. On the core
// side, data_gnt_o accepts the request in the same cycle and data_rvalid_o is
// a one-cycle pulse carrying data_rdata_o/data_err_o.
module ibex_axi4lite_bridge
    import ibexsis_pkg::*;
#(
    parameter int            AW      = 32,
    parameter int            DW      = 32,
    parameter int            SW      = DW / 8,
    parameter logic [AW-1:0] ADDR_LO = AW'(PERIPH_LO),
    parameter logic [AW-1:0] ADDR_HI = AW'(PERIPH_HI)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    // core data port
    input  logic          data_req_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    input  logic          data_we_i,
    input  logic [SW-1:0] data_be_i,
    input  logic [AW-1:0] data_addr_i,
    input  logic [DW-1:0] data_wdata_i,
    output logic [DW-1:0] data_rdata_o,
    output logic          data_err_o,
    // AXI4-lite write address
    output logic [AW-1:0] awaddr_o,
    output logic          awvalid_o,
    input  logic          awready_i,
    // AXI4-lite write data
    output logic [DW-1:0] wdata_o,
    output logic [SW-1:0] wstrb_o,
    output logic          wvalid_o,
    input  logic          wready_i,
    // AXI4-lite write response
    input  logic          bvalid_i,
    input  logic [1:0]    bresp_i,
    output logic          bready_o,
    // AXI4-lite read address
    output logic [AW-1:0] araddr_o,
    output logic          arvalid_o,
    input  logic          arready_i,
    // AXI4-lite read data
    input  logic          rvalid_i,
    input  logic [1:0]    rresp_i,
    input  logic [DW-1:0] rdata_i,
    output logic          rready_o,
    // debug view of the sequencer
    output bridge_state_e state_o
);

    bridge_state_e state_q;
    logic [AW-1:0] addr_q;
    logic [SW-1:0] be_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic          rvalid_q;
    logic          awvalid_q;
    logic          wvalid_q;
    logic          arvalid_q;
    logic          bready_q;
    logic          rready_q;
    logic          in_win;
    logic          aw_done;
    logic          w_done;

    addr_window_check #(
        .AW      (AW),
        .ADDR_LO (ADDR_LO),
        .ADDR_HI (ADDR_HI)
    ) u_win (
        .addr   (data_addr_i),
        .in_win (in_win)
    );

    // Accept only when no transaction is in flight.
    assign data_gnt_o = data_req_i && (state_q == IDLE);

    // A write channel is finished once its valid is gone or handshakes now.
    assign aw_done = !awvalid_q || awready_i;
    assign w_done  = !wvalid_q  || wready_i;

    // Sequencer: captures the request, drives the AXI channels, returns the response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (data_gnt_o) begin
                        addr_q  <= {data_addr_i[AW-1:2], 2'b00};
                        be_q    <= data_be_i;
                        wdata_q <= data_wdata_i;
                        if (!in_win) begin
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b1;
                            rdata_q  <= '0;
                        end else if (data_we_i) begin
                            state_q   <= WADDR_DATA;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= RADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                WADDR_DATA: begin
                    if (awvalid_q && awready_i) awvalid_q <= 1'b0;
                    if (wvalid_q && wready_i)   wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        state_q  <= WRESP;
                        bready_q <= 1'b1;
                    end
                end
                WRESP: begin
                    if (bvalid_i) begin
                        state_q  <= RESP;
                        bready_q <= 1'b0;
                        err_q    <= (bresp_i & RESP_SLVERR) != RESP_OKAY;
                        rdata_q  <= '0;
                        rvalid_q <= 1'b1;
                    end
                end
                RADDR: begin
                    if (arready_i) begin
                        state_q   <= RDATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                RDATA: begin
                    if (rvalid_i) begin
                        state_q  <= RESP;
                        rready_q <= 1'b0;
                        err_q    <= (rresp_i & RESP_SLVERR) != RESP_OKAY;
                        rdata_q  <= rdata_i;
                        rvalid_q <= 1'b1;
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    rvalid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;
    assign awaddr_o      = addr_q;
    assign awvalid_o     = awvalid_q;
    assign wdata_o       = wdata_q;
    assign wstrb_o       = be_q;
    assign wvalid_o      = wvalid_q;
    assign bready_o      = bready_q;
    assign araddr_o      = addr_q;
    assign arvalid_o     = arvalid_q;
    assign rready_o      = rready_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_ibex_axi4lite_bridge.sv
// Bench for ibex_axi4lite_bridge: directed cases from the test plan followed
// by randomized traffic against a transaction-level reference model.
module tb_ibex_axi4lite_bridge;
  import ibexsis_pkg::*;

  localparam int W = 65;  // {due_cycle[31:0], err, rdata[31:0]}

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [3:0]    data_be_i;
  logic [31:0]   data_addr_i, data_wdata_i, data_rdata_o;
  logic [31:0]   awaddr_o, wdata_o, araddr_o, rdata_i;
  logic [3:0]    wstrb_o;
  logic          awvalid_o, awready_i, wvalid_o, wready_i;
  logic          bvalid_i, bready_o, arvalid_o, arready_i, rvalid_i, rready_o;
  logic [1:0]    bresp_i, rresp_i;
  bridge_state_e state_o;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          aw_d, w_d, b_d, ar_d, r_d;
  } txn_t;

  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [W-1:0]  exp_q[$];
  txn_t          cur;
  bit            spur;
  int            aw_hs_at, w_hs_at;

  ibex_axi4lite_bridge dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bvalid_i(bvalid_i), .bresp_i(bresp_i), .bready_o(bready_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rvalid_i(rvalid_i), .rresp_i(rresp_i), .rdata_i(rdata_i), .rready_o(rready_o),
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= 32'h4000) && (a < 32'h40D8);
  endfunction

  // Reference model: response and the cycle (relative to the grant cycle) it appears in.
  function automatic logic [W-1:0] model(input txn_t t, input int base);
    int          lat;
    logic        err;
    logic [31:0] rd;
    if (!in_win(t.addr)) begin
      lat = 1; err = 1'b1; rd = '0;
    end else if (t.we) begin
      lat = 3 + ((t.aw_d > t.w_d) ? t.aw_d : t.w_d) + t.b_d; err = t.resp[1]; rd = '0;
    end else begin
      lat = 3 + t.ar_d + t.r_d; err = t.resp[1]; rd = t.rdata;
    end
    return {32'(base + lat), err, rd};
  endfunction

  function automatic txn_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [1:0] resp, input int aw_d, input int w_d,
                              input int b_d, input int ar_d, input int r_d);
    txn_t t;
    t.we = we; t.be = be; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.resp = resp;
    t.aw_d = aw_d; t.w_d = w_d; t.b_d = b_d; t.ar_d = ar_d; t.r_d = r_d;
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input txn_t t);
    int waited;
    bit got;
    @(negedge clk);
    data_req_i = 1'b1; data_we_i = t.we; data_be_i = t.be;
    data_addr_i = t.addr; data_wdata_i = t.wdata;
    waited = 0; got = 0;
    while (!got && waited < 100) begin
      #1;
      check("gnt", 64'(data_gnt_o), 64'(exp_q.size() == 0));
      if (data_gnt_o) got = 1;
      else begin
        waited++;
        @(negedge clk);
      end
    end
    check("gnt wait", 64'(got), 64'(1));
    if (got) begin
      cur = t;
      aw_hs_at = 1 << 30;
      w_hs_at  = 1 << 30;
      exp_q.push_back(model(t, cyc));
    end
  endtask

  task automatic release_req();
    @(negedge clk);
    data_req_i = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      #3;
      waited++;
    end
    check("response wait", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic idle_spurious();
    spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst awvalid", 64'(awvalid_o), 64'(0));
    check("rst wvalid", 64'(wvalid_o), 64'(0));
    check("rst arvalid", 64'(arvalid_o), 64'(0));
    check("rst bready", 64'(bready_o), 64'(0));
    check("rst rready", 64'(rready_o), 64'(0));
    check("rst data_rvalid", 64'(data_rvalid_o), 64'(0));
    check("rst data_rdata", 64'(data_rdata_o), 64'(0));
    check("rst data_err", 64'(data_err_o), 64'(0));
    check("rst awaddr", 64'(awaddr_o), 64'(0));
    check("rst wdata", 64'(wdata_o), 64'(0));
    check("rst wstrb", 64'(wstrb_o), 64'(0));
    check("rst state", 64'(state_o), 64'(IDLE));
    check("rst gnt", 64'(data_gnt_o), 64'(0));
  endtask

  // ---------------- AXI slave model ----------------
  initial begin : aw_slave
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        awready_i = 1'b0; cnt = 0;
      end else if (awready_i) begin
        awready_i = 1'b0;
        check("awvalid drop", 64'(awvalid_o), 64'(0));
      end else if (awvalid_o) begin
        check("aw expected", 64'(cur.we && in_win(cur.addr)), 64'(1));
        check("awaddr", 64'(awaddr_o), 64'({cur.addr[31:2], 2'b00}));
        if (cnt >= cur.aw_d) begin
          awready_i = 1'b1; cnt = 0; aw_hs_at = cyc + 1;
        end else cnt++;
      end
    end
  end

  initial begin : w_slave
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        wready_i = 1'b0; cnt = 0;
      end else if (wready_i) begin
        wready_i = 1'b0;
        check("wvalid drop", 64'(wvalid_o), 64'(0));
      end else if (wvalid_o) begin
        check("w expected", 64'(cur.we && in_win(cur.addr)), 64'(1));
        check("wdata", 64'(wdata_o), 64'(cur.wdata));
        check("wstrb", 64'(wstrb_o), 64'(cur.be));
        if (cnt >= cur.w_d) begin
          wready_i = 1'b1; cnt = 0; w_hs_at = cyc + 1;
        end else cnt++;
      end
    end
  end

  initial begin : b_slave
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        bvalid_i = 1'b0; cnt = 0;
      end else if (bvalid_i) begin
        bvalid_i = 1'b0; bresp_i = 2'b00;
      end else if (bready_o) begin
        check("bready expected", 64'(cur.we && in_win(cur.addr)), 64'(1));
        check("bready after aw and w", 64'(aw_hs_at <= cyc && w_hs_at <= cyc), 64'(1));
        if (cnt >= cur.b_d) begin
          bvalid_i = 1'b1; bresp_i = cur.resp; cnt = 0;
        end else cnt++;
      end else if (spur) begin
        bvalid_i = 1'b1; bresp_i = 2'b10;
      end
    end
  end

  initial begin : ar_slave
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        arready_i = 1'b0; cnt = 0;
      end else if (arready_i) begin
        arready_i = 1'b0;
        check("arvalid drop", 64'(arvalid_o), 64'(0));
      end else if (arvalid_o) begin
        check("ar expected", 64'(!cur.we && in_win(cur.addr)), 64'(1));
        check("araddr", 64'(araddr_o), 64'({cur.addr[31:2], 2'b00}));
        if (cnt >= cur.ar_d) begin
          arready_i = 1'b1; cnt = 0;
        end else cnt++;
      end
    end
  end

  initial begin : r_slave
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        rvalid_i = 1'b0; cnt = 0;
      end else if (rvalid_i) begin
        rvalid_i = 1'b0; rresp_i = 2'b00;
      end else if (rready_o) begin
        check("rready expected", 64'(!cur.we && in_win(cur.addr)), 64'(1));
        if (cnt >= cur.r_d) begin
          rvalid_i = 1'b1; rresp_i = cur.resp; rdata_i = cur.rdata; cnt = 0;
        end else cnt++;
      end else if (spur) begin
        rvalid_i = 1'b1; rresp_i = 2'b10; rdata_i = 32'hBAD0_BAD0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [W-1:0] e;
    logic [31:0]  last_rdata;
    logic         last_err;
    logic         prev_rv;
    last_rdata = '0; last_err = 1'b0; prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_ni) begin
        last_rdata = '0; last_err = 1'b0; prev_rv = 1'b0;
      end else begin
        if (data_rvalid_o) begin
          check("rvalid pulse width", 64'(prev_rv), 64'(0));
          if (exp_q.size() == 0) begin
            check("rvalid with nothing outstanding", 64'(exp_q.size()), 64'(1));
          end else begin
            e = exp_q.pop_front();
            check("resp rdata", 64'(data_rdata_o), 64'(e[31:0]));
            check("resp err", 64'(data_err_o), 64'(e[32]));
            check("resp cycle", 64'(cyc), 64'(e[64:33]));
          end
          last_rdata = data_rdata_o;
          last_err   = data_err_o;
        end else begin
          check("rdata hold", 64'(data_rdata_o), 64'(last_rdata));
          check("err hold", 64'(data_err_o), 64'(last_err));
        end
        prev_rv = data_rvalid_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    txn_t        t;
    logic [31:0] a;
    int          waited;

    rst_ni = 1'b0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
    awready_i = 1'b0; wready_i = 1'b0; arready_i = 1'b0;
    bvalid_i = 1'b0; bresp_i = '0; rvalid_i = 1'b0; rresp_i = '0; rdata_i = '0;
    spur = 1'b0; aw_hs_at = 0; w_hs_at = 0;
    cur = mk(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 2'b00, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    rst_ni = 1'b1;

    // zero-wait write
    issue(mk(1'b1, 4'hF, 32'h4008, 32'hDEADBEEF, 32'h0, RESP_OKAY, 0, 0, 0, 0, 0));
    release_req(); wait_idle();
    // read with arready delayed
    issue(mk(1'b0, 4'hF, 32'h4018, 32'h0, 32'h12345678, RESP_OKAY, 0, 0, 0, 3, 0));
    release_req(); wait_idle();
    // wready two cycles ahead of awready
    issue(mk(1'b1, 4'h3, 32'h4040, 32'hA5A5_0F0F, 32'h0, RESP_OKAY, 2, 0, 1, 0, 0));
    release_req(); wait_idle();
    // out of window on both sides
    issue(mk(1'b0, 4'hF, 32'h40D8, 32'h0, 32'hFFFF_FFFF, RESP_OKAY, 0, 0, 0, 0, 0));
    release_req(); wait_idle();
    issue(mk(1'b1, 4'hF, 32'h3FFC, 32'h1111_2222, 32'h0, RESP_OKAY, 0, 0, 0, 0, 0));
    release_req(); wait_idle();
    // window edges and misaligned address
    issue(mk(1'b0, 4'hF, 32'h4000, 32'h0, 32'h0BAD_CAFE, RESP_OKAY, 0, 0, 0, 0, 1));
    release_req(); wait_idle();
    issue(mk(1'b1, 4'hC, 32'h40D4, 32'h7766_5544, 32'h0, RESP_OKAY, 1, 1, 0, 0, 0));
    release_req(); wait_idle();
    issue(mk(1'b1, 4'h6, 32'h4013, 32'h0102_0304, 32'h0, RESP_OKAY, 0, 2, 0, 0, 0));
    release_req(); wait_idle();
    // slave error responses, then OKAY
    issue(mk(1'b1, 4'hF, 32'h4020, 32'h5555_AAAA, 32'h0, RESP_SLVERR, 0, 0, 2, 0, 0));
    release_req(); wait_idle();
    issue(mk(1'b0, 4'hF, 32'h4024, 32'h0, 32'h8765_4321, RESP_SLVERR, 0, 0, 0, 1, 2));
    release_req(); wait_idle();
    issue(mk(1'b0, 4'hF, 32'h4028, 32'h0, 32'h2468_ACE0, RESP_OKAY, 0, 0, 0, 0, 0));
    release_req(); wait_idle();
    idle_spurious();

    // back-to-back with request held high
    for (int i = 0; i < 5; i++) begin
      t = mk(1'(i % 2), 4'(i + 3), 32'h4030 + 32'(i * 4), $urandom, $urandom, RESP_OKAY, 0, 0, 0, 0, 0);
      issue(t);
    end
    release_req(); wait_idle();

    // reset while waiting for read data
    issue(mk(1'b0, 4'hF, 32'h4050, 32'h0, 32'hCAFE_F00D, RESP_OKAY, 0, 0, 0, 0, 8));
    release_req();
    waited = 0;
    while (!rready_o && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("reach RDATA", 64'(rready_o), 64'(1));
    @(negedge clk);
    rst_ni = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    issue(mk(1'b0, 4'hF, 32'h4054, 32'h0, 32'h1357_9BDF, RESP_OKAY, 0, 0, 0, 0, 0));
    release_req(); wait_idle();

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom_range(32'h3FF0, 32'h3FFF);
        1:       a = $urandom_range(32'h40D8, 32'h40F0);
        default: a = $urandom_range(32'h4000, 32'h40D7);
      endcase
      t = mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, $urandom,
             2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      issue(t);
      if ($urandom_range(0, 2) == 0) begin
        release_req();
        wait_idle();
        if ($urandom_range(0, 3) == 0) idle_spurious();
      end
    end
    release_req();
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
